// File: rtl/lsu_mem_access_if.sv
// Bundle of the load/store request, response and data-memory port signals.
// The slave view belongs to the load/store unit; the master view to its environment.
interface lsu_mem_access_if #(
    parameter int BITS  = 64,
    parameter int IDX_W = 5
);
    // Both request and response move on a clk edge where valid and ready are high.
    // A valid holds its payload stable until that edge.
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [IDX_W+2:0]  req_addr;
    logic [BITS-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [BITS-1:0]   resp_rdata;
    logic              resp_err;
    logic [IDX_W-1:0]  mem_endr;
    logic              mem_we;
    logic [BITS-1:0]   mem_din;
    logic [BITS-1:0]   mem_dout;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_endr, mem_we, mem_din
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_endr, mem_we, mem_din
    );
endinterface

// File: rtl/lsu_mem_access.sv
// Load/store unit driving a 64-bit word memory with no byte enables.
// Narrow stores are read-modify-write; loads return sign- or zero-extended lanes.
module lsu_mem_access #(
    parameter int BITS  = 64,
    parameter int IDX_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    lsu_mem_access_if.slave     bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;

    logic              st_q;
    logic [2:0]        f3_q;
    logic [IDX_W+2:0]  addr_q;
    logic [BITS-1:0]   wdata_q;

    logic              resp_valid_q;
    logic [BITS-1:0]   resp_rdata_q;
    logic              resp_err_q;
    logic [IDX_W-1:0]  mem_endr_q;
    logic              mem_we_q;
    logic [BITS-1:0]   mem_din_q;

    logic              req_bad;
    logic              req_misaligned;
    logic              req_is_sd;
    logic [5:0]        lane_shift;
    logic [BITS-1:0]   lane;
    logic [BITS-1:0]   load_ext;
    logic [BITS-1:0]   size_mask;
    logic [BITS-1:0]   merged;

    // Request decode, evaluated against the live request in IDLE.
    always_comb begin
        req_misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = bus.req_addr[0];
            2'b10:   req_misaligned = |bus.req_addr[1:0];
            default: req_misaligned = |bus.req_addr[2:0];
        endcase
        req_bad = req_misaligned
                | (bus.req_store & bus.req_funct3[2])
                | (~bus.req_store & (bus.req_funct3 == 3'b111));
        req_is_sd = bus.req_store & (bus.req_funct3[1:0] == 2'b11);
    end

    // Lane extraction for loads and byte-lane merge for narrow stores.
    always_comb begin
        lane_shift = {addr_q[2:0], 3'b000};
        lane       = bus.mem_dout >> lane_shift;
        load_ext   = '0;
        size_mask  = '0;
        case (f3_q[1:0])
            2'b00: begin
                load_ext  = f3_q[2] ? {56'd0, lane[7:0]} : {{56{lane[7]}}, lane[7:0]};
                size_mask = 64'h0000_0000_0000_00FF;
            end
            2'b01: begin
                load_ext  = f3_q[2] ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
                size_mask = 64'h0000_0000_0000_FFFF;
            end
            2'b10: begin
                load_ext  = f3_q[2] ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
                size_mask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                load_ext  = lane;
                size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase
        merged = (bus.mem_dout & ~(size_mask << lane_shift))
               | ((wdata_q << lane_shift) & (size_mask << lane_shift));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            st_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_endr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_din_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        st_q    <= bus.req_store;
                        f3_q    <= bus.req_funct3;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        if (req_bad) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
                        end else if (req_is_sd) begin
                            // A full-word store needs no read, so it skips ACCESS.
                            mem_endr_q <= bus.req_addr[IDX_W+2:3];
                            mem_we_q   <= 1'b1;
                            mem_din_q  <= bus.req_wdata;
                            state      <= WRITE;
                        end else begin
                            mem_endr_q <= bus.req_addr[IDX_W+2:3];
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (st_q) begin
                        mem_we_q  <= 1'b1;
                        mem_din_q <= merged;
                        state     <= WRITE;
                    end else begin
                        mem_endr_q   <= '0;
                        resp_rdata_q <= load_ext;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                WRITE: begin
                    mem_we_q     <= 1'b0;
                    mem_endr_q   <= '0;
                    mem_din_q    <= '0;
                    resp_rdata_q <= '0;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_endr   = mem_endr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_din    = mem_din_q;
    assign dbg_state      = state;

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
Load/store unit that acts as the requester side of the 64-bit, 32-entry data memory port (index, write enable, write data, combinational read data). It takes RISC-V load/store requests from the execute stage and converts them into memory accesses. Byte, half and word stores are done as read-modify-write, because the memory has no byte enables. Load results are returned sign- or zero-extended over a valid/ready response handshake.

Parameters:
BITS, 64, data width; only 64 is supported.
IDX_W, 5, memory index width; byte address width is IDX_W+3.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  request accepted on a clk edge where req_valid and req_ready are both high.
req_store  input  1  1 = store, 0 = load.
req_funct3  input  3  RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD).
req_addr  input  IDX_W+3  byte address.
req_wdata  input  BITS  store data, taken from its LSBs.
resp_valid  output  1  response present.
resp_ready  input  1  response consumed.
resp_rdata  output  BITS  extended load data; 0 for stores and errors.
resp_err  output  1  misaligned access or illegal funct3.
mem_endr  output  IDX_W  memory index.
mem_we  output  1  memory write enable.
mem_din  output  BITS  memory write data.
mem_dout  input  BITS  memory read data, combinational from mem_endr.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0, mem_endr=0, mem_din=0.
  - req_ready=1 (req_ready is decoded as state==IDLE).
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - On accept, latch store, funct3, addr and wdata.
  - Size comes from funct3[1:0]: 00=1 byte, 01=2, 10=4, 11=8.
  - Misaligned means addr not a multiple of size. Illegal means a store with funct3[2]=1, or a load with funct3=111.
  - Error -> RESP with resp_err=1; no memory access is made.
  - Store with size 8 -> WRITE.
  - Otherwise -> ACCESS.
- ACCESS, one cycle:
  - mem_endr=addr[7:3], mem_we=0; capture mem_dout at the clock edge.
  - Load: select the lane at byte offset addr[2:0]. Sign-extend when funct3[2]=0, zero-extend when funct3[2]=1. Register into resp_rdata -> RESP.
  - Store: merged word = captured word with lane bytes [off, off+size) replaced by req_wdata LSBs -> WRITE.
- WRITE, one cycle:
  - mem_endr=addr[7:3], mem_we=1, mem_din=merged word (full wdata for SD) -> RESP.
  - mem_we is high for exactly one cycle per store and never in any other state.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready=1 at a clock edge, then -> IDLE.
  - Back-to-back: the next request can be accepted one cycle after the response handshake.
- Outside ACCESS and WRITE: mem_endr=0, mem_din=0.
- Latency, from the accept edge to resp_valid high:
  - load: 2 cycles.
  - narrow store: 3 cycles.
  - SD: 2 cycles.
  - error: 1 cycle.
- req_ready=0 in ACCESS, WRITE and RESP; req_valid in those states is ignored and nothing is latched.
- Reset during WRITE: mem_we drops asynchronously; the write is not guaranteed and the response is discarded.
- Reset during RESP: the pending response is dropped.
- Address wrap: index = addr[7:3] only; no out-of-range case exists.

Test Plan:
1. Reset, then memory word0=51; LD addr 0x00 -> resp_valid 2 cycles after accept, resp_rdata=51, resp_err=0, mem_we never high.
2. Word2=94 (0x5E); SB addr 0x11 wdata 0xAB -> exactly one mem_we pulse at mem_endr=2, mem_din=0x000000000000AB5E; response rdata=0, err=0.
3. SB addr 0x28 wdata 0x80 -> word5 low byte becomes 0x80, so word5=0x80 (previous 18 overwritten). Then:
   - LB 0x28 -> 0xFFFFFFFFFFFFFF80.
   - LBU 0x28 -> 0x0000000000000080.
   - SH 0x2E wdata 0x8001, then LH 0x2E -> 0xFFFFFFFFFFFF8001.
4. LW addr 0x02 and SD addr 0x0C -> each gives resp_err=1 and resp_rdata=0 one cycle after accept; no mem_we; memory unchanged. Store with funct3=100 -> resp_err=1.
5. LD completes; resp_ready held low for 3 cycles while req_valid=1 -> resp_valid and rdata stable, req_ready=0, nothing accepted. resp_ready=1 -> IDLE; the next request is accepted the following cycle.
6. rst_n low during the WRITE cycle of an SB -> mem_we=0 immediately, all outputs at reset values, req_ready=1. A new LD after release completes normally.
